// File: rtl/irq_encoder8_if.sv
// irq_encoder8_if: request/offer bundle for irq_encoder8.
//   req        8  request strobes from the event sources
//   mask       8  per-source enable for selection
//   out_ready  1  consumer accepts the current offer
//   out_valid  1  an index is on offer
//   out_idx    3  encoded index of the offered source
//   out_onehot 8  one-hot form of out_idx, zero when nothing is offered
//   pending    8  pending register, for CP0/debug read
// The master modport is the source/consumer side; the slave modport is the encoder.
interface irq_encoder8_if;
    logic [7:0] req;
    logic [7:0] mask;
    logic       out_ready;
    logic       out_valid;
    logic [2:0] out_idx;
    logic [7:0] out_onehot;
    logic [7:0] pending;

    modport master (
        output req,
        output mask,
        output out_ready,
        input  out_valid,
        input  out_idx,
        input  out_onehot,
        input  pending
    );

    modport slave (
        input  req,
        input  mask,
        input  out_ready,
        output out_valid,
        output out_idx,
        output out_onehot,
        output pending
    );
endinterface

// File: rtl/irq_encoder8.sv
// irq_encoder8: 8-source request encoder with pending capture and a valid/ready offer.
// Requests are latched into a pending register; one eligible (pending & mask) source
// is offered at a time as a registered 3-bit index plus its one-hot form.
// Ports:
//   clk     system clock, rising edge
//   resetn  asynchronous active-low reset
//   bus     irq_encoder8_if slave modport (req, mask, out_ready in; out_valid,
//           out_idx, out_onehot, pending out)
// ROUND_ROBIN = 0 selects fixed priority (bit 0 highest); 1 searches from the
// index after the last granted one.
module irq_encoder8 #(
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic           clk,
    input  logic           resetn,
    irq_encoder8_if.slave  bus
);

    typedef enum logic {StIdle, StOffer} state_e;

    state_e     state_q, state_d;
    logic [7:0] pending_q, pending_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] onehot_q, onehot_d;
    logic [2:0] ptr_q, ptr_d;

    logic [7:0] eligible;
    logic [2:0] sel_idx;
    logic       sel_found;
    logic [2:0] rr_cand;
    logic       handshake;

    // Source selection. Loops run from the lowest-priority candidate upwards so the
    // last hit (the highest-priority one) wins without needing an early exit.
    always_comb begin
        eligible  = pending_q & bus.mask;
        sel_idx   = 3'd0;
        sel_found = 1'b0;
        rr_cand   = 3'd0;
        if (ROUND_ROBIN) begin
            // k = 8 wraps to ptr itself, which is last in the search order.
            for (int k = 8; k >= 1; k--) begin
                rr_cand = ptr_q + 3'(k);
                if (eligible[rr_cand]) begin
                    sel_idx   = rr_cand;
                    sel_found = 1'b1;
                end
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (eligible[i]) begin
                    sel_idx   = 3'(i);
                    sel_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        handshake = (state_q == StOffer) && bus.out_ready;

        // Clear first, then OR in new requests so a same-cycle set wins.
        pending_d = pending_q;
        if (handshake) begin
            pending_d[idx_q] = 1'b0;
        end
        pending_d = pending_d | bus.req;

        state_d  = state_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
        ptr_d    = ptr_q;

        unique case (state_q)
            StIdle: begin
                if (sel_found) begin
                    state_d  = StOffer;
                    idx_d    = sel_idx;
                    onehot_d = 8'b1 << sel_idx;
                end
            end
            StOffer: begin
                // The offer is held until accepted, whatever happens to mask or req.
                if (bus.out_ready) begin
                    state_d  = StIdle;
                    onehot_d = 8'h00;
                    ptr_d    = idx_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            pending_q <= 8'h00;
            idx_q     <= 3'd0;
            onehot_q  <= 8'h00;
            ptr_q     <= 3'd7;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
            onehot_q  <= onehot_d;
            ptr_q     <= ptr_d;
        end
    end

    assign bus.out_valid  = (state_q == StOffer);
    assign bus.out_idx    = idx_q;
    assign bus.out_onehot = onehot_q;
    assign bus.pending    = pending_q;

endmodule

// File: doc/irq_encoder8.md
# irq_encoder8

8-source request encoder with pending capture and a valid/ready handshake; it is the encoding counterpart of the 3-to-8 one-hot decoder. Request strobes from up to eight sources (interrupt lines, cache-way hit or miss events, exception causes) are latched into a pending register. One pending source is selected per handshake, by fixed priority or round-robin, and presented as a stable 3-bit index plus its one-hot form. It sits between event sources and the pipeline or CP0 consumer that services them one at a time.

## Interface
- ROUND_ROBIN, default 0: 0 selects fixed priority (bit 0 highest); 1 selects round-robin starting after the last granted index.
- clk  input  1  system clock; all state updates on the rising edge.
- resetn  input  1  asynchronous active-low reset.
- req  input  8  request strobes; any cycle with req[i]=1 sets pending[i].
- mask  input  8  enable per source; only pending & mask is eligible for selection.
- out_ready  input  1  consumer accepts the offered index this cycle.
- out_valid  output  1  an index is on offer.
- out_idx  output  3  encoded index of the offered source.
- out_onehot  output  8  one-hot form of out_idx; all zero when out_valid=0.
- pending  output  8  current pending register, for CP0/debug read.

## Operation
- Pending register:
  - pending[i] sets on any cycle with req[i]=1.
  - pending[i] clears on the edge that completes a handshake (out_valid && out_ready) for out_idx==i.
  - Simultaneous set and clear of the same bit: set wins, so the bit stays 1.
- FSM states:
  - IDLE: out_valid=0.
  - OFFER: out_valid=1; out_idx and out_onehot are registered and held constant.
- IDLE → OFFER when eligible = pending & mask is nonzero; the selected index is loaded on the same edge.
- IDLE stays IDLE when eligible = 0.
- OFFER → IDLE on handshake. No back-to-back offers: there is always one IDLE cycle between offers.
- OFFER holds while out_ready=0. out_idx must not change, even if mask later clears that bit or a higher-priority request arrives. The offer is never retracted.
- Fixed priority: select the lowest set index of eligible.
- Round-robin:
  - Pointer ptr (3 bits) resets to 7.
  - Search order is ptr+1, ptr+2, … wrapping modulo 8; select the first eligible bit.
  - On each handshake, ptr ← out_idx.
  - ptr is ignored when ROUND_ROBIN=0.
- mask does not affect capture: a masked request stays pending and becomes eligible once unmasked.
- The out_onehot encoding is 1<<out_idx and must round-trip exactly through the 3-to-8 decoder.

## Timing
- Reset (asynchronous, immediate, while resetn=0):
  - state=IDLE.
  - out_valid=0, out_idx=3'd0, out_onehot=8'h00, pending=8'h00, ptr=3'd7.
- Latency:
  - req[i] high in cycle 0 → pending[i]=1 in cycle 1.
  - With i eligible and selected, out_valid=1 with out_idx=i in cycle 2.
- Handshake in cycle k:
  - Cycle k+1: out_valid=0 and the pending bit is cleared.
  - The next offer appears no earlier than cycle k+2.
- out_ready is ignored when out_valid=0. out_ready is not required to wait for out_valid.
- All outputs are registered; there is no combinational path from req, mask or out_ready to any output.
- Reset asserted mid-OFFER: the offer is dropped and all pending state is lost. After release, new requests are needed.
- Every source requesting continuously (req=8'hFF every cycle):
  - Fixed priority grants index 0 forever.
  - Round-robin grants 0,1,…,7,0,… in order, one per handshake.

## Test plan
- Reset: drive resetn=0 mid-operation with pending=8'hA5 and out_valid=1 → all outputs read 0 immediately and ptr=7. After release with req=0, out_valid stays 0.
- Basic latency: single-cycle req=8'h10 in cycle 0 with mask=8'hFF and out_ready=1 → pending=8'h10 in cycle 1; cycle 2 shows out_valid=1, out_idx=4, out_onehot=8'h10; cycle 3 shows pending=0 and out_valid=0.
- Fixed priority and stall: req=8'h82 pulsed, out_ready=0 for 5 cycles → out_idx=1 held stable for all 5. Pulse req[0] during the stall → out_idx stays 1. After acceptance, the following offers are idx 0, then idx 7.
- Round-robin (ROUND_ROBIN=1): req=8'hFF held continuously, out_ready=1 → grant sequence 0,1,2,…,7,0 with one idle cycle between grants.
- Mask: req=8'h0C pulsed with mask=8'h08 → only idx 3 offered; pending stays 8'h04. Set mask=8'hFF → idx 2 offered two cycles later.
- Set/clear collision: req[5] asserted in the same cycle as the handshake of idx 5 → pending[5] remains 1, and idx 5 is re-offered at cycle k+2.
